hazard_ctrl: RTL and testbench

- Central pipeline-control unit for the riscv32i core.
- Drives the `stall`/`flush` inputs of every `pipeline_reg` instance and the PC hold.
- Resolves three hazard sources:
  - load-use data hazards (ID vs EX);
  - taken-branch/jump redirects (from EX);
  - multi-cycle data-memory waits (MEM stage handshake), with a timeout watchdog.

---
 rtl/core_pkg.sv | 22 ++
 rtl/hazard_ctrl_if.sv | 45 ++++
 rtl/mem_wait_fsm.sv | 78 +++++++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core package: hazard FSM state encodings, the default register-index
// width and a helper that sizes the memory-wait counter.
package core_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_RECOVER  = 2'd2
  } hz_state_e;

  // Bits needed to hold 0..max_count, never less than one.
  function automatic int cnt_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end else begin
      return $clog2(max_count + 1);
    end
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline (master) and hazard_ctrl (slave):
// ID/EX/MEM hazard inputs and the stall/flush/debug outputs.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W_DEF
);

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;

  logic stall_pc;
  logic stall_ifid;
  logic stall_idex;
  logic stall_exmem;
  logic stall_memwb;
  logic flush_ifid;
  logic flush_idex;
  logic flush_exmem;
  logic flush_memwb;
  logic mem_timeout;
  logic [1:0] hz_state;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb,
           mem_timeout, hz_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb,
           mem_timeout, hz_state
  );

endinterface

// File: rtl/mem_wait_fsm.sv
// Memory-wait tracker: RUN / MEM_WAIT / RECOVER state, saturating wait counter
// and the sticky watchdog flag that trips after MEM_TIMEOUT wait cycles.
module mem_wait_fsm
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_busy_i,
  input  logic       mem_ready_i,
  output logic [1:0] state_o,
  output logic       timeout_o
);

  localparam int CNT_W = cnt_width(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // State, counter and watchdog registers; reset aborts any wait at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HZ_RUN;
      cnt_q     <= CNT_ZERO;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic; counter clears in RUN so every wait starts from zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      HZ_RUN: begin
        cnt_d = CNT_ZERO;
        if (mem_busy_i) begin
          state_d = HZ_MEM_WAIT;
        end else begin
          state_d = HZ_RUN;
        end
      end
      HZ_MEM_WAIT: begin
        if (mem_ready_i) begin
          state_d = HZ_RUN;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HZ_RECOVER;
          timeout_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      HZ_RECOVER: begin
        state_d = HZ_RUN;
      end
      default: begin
        state_d = HZ_RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign state_o   = state_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline hazard controller: load-use, taken-branch redirect and
// data-memory wait handling with watchdog. Optional HAZARD_PERF_CNT_EN adds
// stall_cycles / flush_events performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  flush_events
`endif
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  logic       mem_busy_s;
  logic       load_use_s;
  logic [1:0] state_s;
  logic       timeout_s;
  logic       stall_pc_s, stall_ifid_s, stall_idex_s, stall_exmem_s, stall_memwb_s;
  logic       flush_ifid_s, flush_idex_s, flush_memwb_s;

  assign mem_busy_s = hz.mem_req && !hz.mem_ready;

  // x0 is never a real dependency, so a load into x0 does not stall.
  assign load_use_s = hz.ex_mem_read && (hz.ex_rd != REG_ZERO) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk         (clk),
    .reset       (reset),
    .mem_busy_i  (mem_busy_s),
    .mem_ready_i (hz.mem_ready),
    .state_o     (state_s),
    .timeout_o   (timeout_s)
  );

  // Priority mux: memory stall, recovery, redirect, then load-use bubble.
  always_comb begin
    stall_pc_s    = 1'b0;
    stall_ifid_s  = 1'b0;
    stall_idex_s  = 1'b0;
    stall_exmem_s = 1'b0;
    stall_memwb_s = 1'b0;
    flush_ifid_s  = 1'b0;
    flush_idex_s  = 1'b0;
    flush_memwb_s = 1'b0;
    if (reset) begin
      stall_pc_s = 1'b0;
    end else if (mem_busy_s) begin
      // EX/ID are frozen, so redirects and load-use re-evaluate next cycle.
      stall_pc_s    = 1'b1;
      stall_ifid_s  = 1'b1;
      stall_idex_s  = 1'b1;
      stall_exmem_s = 1'b1;
      stall_memwb_s = 1'b1;
      flush_memwb_s = 1'b1;
    end else if (state_s == HZ_RECOVER) begin
      // Drop the timed-out access and let the pipe advance.
      flush_memwb_s = 1'b1;
    end else if (hz.ex_branch_taken) begin
      // The dependent instruction is squashed, so load-use is moot.
      flush_ifid_s = 1'b1;
      flush_idex_s = 1'b1;
    end else if (load_use_s) begin
      stall_pc_s   = 1'b1;
      stall_ifid_s = 1'b1;
      flush_idex_s = 1'b1;
    end else begin
      stall_pc_s = 1'b0;
    end
  end

  assign hz.stall_pc    = stall_pc_s;
  assign hz.stall_ifid  = stall_ifid_s;
  assign hz.stall_idex  = stall_idex_s;
  assign hz.stall_exmem = stall_exmem_s;
  assign hz.stall_memwb = stall_memwb_s;
  assign hz.flush_ifid  = flush_ifid_s;
  assign hz.flush_idex  = flush_idex_s;
  assign hz.flush_exmem = 1'b0;  // reserved for the trap path
  assign hz.flush_memwb = flush_memwb_s;
  assign hz.mem_timeout = timeout_s;
  assign hz.hz_state    = state_s;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  // Free-running, wrapping event counters for stall and flush activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      if (stall_pc_s) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush_ifid_s || flush_idex_s) begin
        flush_events_q <= flush_events_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed and random
// stimulus each cycle and queues the reference model's expected outputs; a
// monitor pops and compares every cycle.
module tb_hazard_ctrl;

  localparam int T = 4;  // watchdog limit used for the DUT instance

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  hazard_ctrl #(
    .REG_ADDR_W  (5),
    .MEM_TIMEOUT (T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hz           (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       mq;
    logic       my;
  } stim_t;

  // stall = {pc,ifid,idex,exmem,memwb}, flush = {ifid,idex,exmem,memwb}
  typedef struct packed {
    logic [4:0]  stall;
    logic [3:0]  flush;
    logic        tmo;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: "waiting" / "recovering" flags, cycles waited so far,
  // sticky timeout and event tallies.
  bit m_wait, m_recover, m_tmo;
  int m_waited, m_sc, m_fe;

  task automatic step(input stim_t s);
    exp_t e;
    bit   busy, lu;
    @(negedge clk);
    reset               = s.rst;
    bus.id_rs1          = s.rs1;
    bus.id_rs2          = s.rs2;
    bus.id_use_rs1      = s.u1;
    bus.id_use_rs2      = s.u2;
    bus.ex_rd           = s.rd;
    bus.ex_mem_read     = s.mr;
    bus.ex_branch_taken = s.br;
    bus.mem_req         = s.mq;
    bus.mem_ready       = s.my;
    busy = s.mq && !s.my;
    lu   = s.mr && (s.rd != 5'd0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    e = '0;
    if (s.rst) begin
      m_wait = 1'b0; m_recover = 1'b0; m_tmo = 1'b0;
      m_waited = 0; m_sc = 0; m_fe = 0;
    end else begin
      if (busy) begin
        e.stall = 5'b11111; e.flush = 4'b0001;
      end else if (m_recover) begin
        e.flush = 4'b0001;
      end else if (s.br) begin
        e.flush = 4'b1100;
      end else if (lu) begin
        e.stall = 5'b11000; e.flush = 4'b0100;
      end
      e.tmo = m_tmo;
      e.st  = m_recover ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
`ifdef HAZARD_PERF_CNT_EN
      e.sc = 32'(m_sc);
      e.fe = 32'(m_fe);
`endif
      m_sc += int'(e.stall[4]);
      m_fe += int'(e.flush[3] | e.flush[2]);
      if (m_recover) begin
        m_recover = 1'b0;
      end else if (m_wait) begin
        if (s.my) begin
          m_wait = 1'b0;
        end else begin
          m_waited++;
          if (m_waited == T) begin
            m_wait = 1'b0; m_recover = 1'b1; m_tmo = 1'b1;
          end
        end
      end else if (busy) begin
        m_wait = 1'b1; m_waited = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the queued expectation every cycle.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '0;
        a.stall = {bus.stall_pc, bus.stall_ifid, bus.stall_idex, bus.stall_exmem, bus.stall_memwb};
        a.flush = {bus.flush_ifid, bus.flush_idex, bus.flush_exmem, bus.flush_memwb};
        a.tmo   = bus.mem_timeout;
        a.st    = bus.hz_state;
`ifdef HAZARD_PERF_CNT_EN
        a.sc = stall_cycles;
        a.fe = flush_events;
`endif
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL cycle_check t=%0t got stall=%b flush=%b tmo=%b st=%0d sc=%0d fe=%0d want stall=%b flush=%b tmo=%b st=%0d sc=%0d fe=%0d",
                   $time, a.stall, a.flush, a.tmo, a.st, a.sc, a.fe,
                   e.stall, e.flush, e.tmo, e.st, e.sc, e.fe);
        end
      end
    end
  end

  // Driver: directed scenarios first, then randomized traffic.
  initial begin
    stim_t s;
    int    lat;
    reset = 1'b1;
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_mem_read = 1'b0; bus.ex_branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

    // reset, including a memory miss that must stay masked
    s = '0; s.rst = 1'b1; step(s);
    s.mq = 1'b1; step(s);
    s = '0; step(s);

    // load-use on rs1, one bubble
    s = '0; s.mr = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1; step(s);
    s = '0; step(s);
    // load into x0: no stall
    s.mr = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1; step(s);
    // rs2 match only counts when rs2 is read
    s = '0; s.mr = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; step(s);
    s.u2 = 1'b1; step(s);
    // branch overrides load-use
    s = '0; s.mr = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1; s.br = 1'b1; step(s);
    s = '0; step(s);

    // memory wait of 3 busy cycles
    s = '0; s.mq = 1'b1; repeat (3) step(s);
    s.my = 1'b1; step(s);
    s = '0; step(s);
    // same with a branch pending throughout
    s = '0; s.mq = 1'b1; s.br = 1'b1; repeat (3) step(s);
    s.my = 1'b1; step(s);
    s.mq = 1'b0; s.my = 1'b0; step(s);
    s = '0; step(s);
    // request completing in its first cycle
    s = '0; s.mq = 1'b1; s.my = 1'b1; step(s);
    s = '0; step(s);

    // watchdog: ready never comes
    s = '0; s.mq = 1'b1; repeat (T + 1) step(s);
    s = '0; repeat (4) step(s);

    // asynchronous reset in the middle of a wait
    s = '0; s.mq = 1'b1; repeat (2) step(s);
    s.rst = 1'b1; step(s);
    s = '0; step(s);
    // full-length wait again proves the counter restarted
    s = '0; s.mq = 1'b1; repeat (T) step(s);
    s.my = 1'b1; step(s);
    s = '0; step(s);

    // randomized traffic
    lat = -1;
    for (int i = 0; i < 800; i++) begin
      s = '0;
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.u1  = 1'($urandom_range(0, 1));
      s.u2  = 1'($urandom_range(0, 1));
      s.mr  = 1'($urandom_range(0, 1));
      s.br  = ($urandom_range(0, 5) == 0);
      if (lat < 0 && $urandom_range(0, 3) == 0) begin
        lat = int'($urandom_range(0, 7));
      end
      if (lat >= 0) begin
        s.mq = 1'b1;
        s.my = (lat == 0);
        lat--;
      end
      s.rst = ($urandom_range(0, 149) == 0);
      step(s);
    end

    s = '0; repeat (3) step(s);
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
